// File: rtl/serial_tx_arbiter_if.sv
// serial_tx_arbiter_if
//   Bundles the two packet-source handshakes, the UART byte port and the
//   status outputs of serial_tx_arbiter.
//   master : packet producers + UART side (drives valid/data/last, tx_ready)
//   slave  : the arbiter (drives acks, tx_data/tx_strobe, busy, owner)
interface serial_tx_arbiter_if;
   logic       s0_valid;
   logic [7:0] s0_data;
   logic       s0_last;
   logic       s0_ack;
   logic       s1_valid;
   logic [7:0] s1_data;
   logic       s1_last;
   logic       s1_ack;
   logic       tx_ready;
   logic [7:0] tx_data;
   logic       tx_strobe;
   logic       busy;
   logic       owner;

   modport master (
      output s0_valid, s0_data, s0_last, s1_valid, s1_data, s1_last, tx_ready,
      input  s0_ack, s1_ack, tx_data, tx_strobe, busy, owner
   );

   modport slave (
      input  s0_valid, s0_data, s0_last, s1_valid, s1_data, s1_last, tx_ready,
      output s0_ack, s1_ack, tx_data, tx_strobe, busy, owner
   );
endinterface

// File: rtl/serial_tx_arbiter.sv
// serial_tx_arbiter
//   Shares one 8-N-1 byte transmitter between two packet sources and frames
//   each packet as FLAG, escaped payload, FLAG (FLAG/ESC payload bytes go out
//   as ESC, byte^XORV). Ties are broken round-robin.
// Ports:
//   mclk  : master clock
//   reset : asynchronous, active-low reset
//   bus   : serial_tx_arbiter_if.slave (source handshakes, UART port, status)
module serial_tx_arbiter #(
   parameter logic [7:0] FLAG = 8'h7E,
   parameter logic [7:0] ESC  = 8'h7D,
   parameter logic [7:0] XORV = 8'h20
) (
   input  logic           mclk,
   input  logic           reset,
   serial_tx_arbiter_if.slave bus
);

   typedef enum logic [2:0] {IDLE, SOF, DATA, ESC2, EOF} state_t;

   state_t     state;
   logic       owner_q;
   logic       last_grant;
   logic       busy_q;
   logic       strobe_q;
   logic       ack0_q;
   logic       ack1_q;
   logic [7:0] data_q;
   logic [7:0] esc_byte;
   logic       esc_last;

   logic       send;
   logic       cur_valid;
   logic       cur_last;
   logic [7:0] cur_data;
   logic       cur_special;

   // A strobe is never issued while the previous one is still on the wire:
   // the UART's ready only drops the cycle after it sees a strobe.
   assign send        = bus.tx_ready & ~strobe_q;
   assign cur_valid   = owner_q ? bus.s1_valid : bus.s0_valid;
   assign cur_last    = owner_q ? bus.s1_last  : bus.s0_last;
   assign cur_data    = owner_q ? bus.s1_data  : bus.s0_data;
   assign cur_special = (cur_data == FLAG) || (cur_data == ESC);

   always_ff @(posedge mclk or negedge reset) begin
      if (!reset) begin
         state      <= IDLE;
         owner_q    <= 1'b0;
         last_grant <= 1'b1;
         busy_q     <= 1'b0;
         strobe_q   <= 1'b0;
         ack0_q     <= 1'b0;
         ack1_q     <= 1'b0;
         data_q     <= 8'h00;
         esc_byte   <= 8'h00;
         esc_last   <= 1'b0;
      end else begin
         strobe_q <= 1'b0;
         ack0_q   <= 1'b0;
         ack1_q   <= 1'b0;
         case (state)
            IDLE: begin
               // busy stays up through the closing-FLAG strobe cycle and
               // drops one cycle later unless a new packet is granted here.
               busy_q <= 1'b0;
               if (bus.s0_valid | bus.s1_valid) begin
                  owner_q <= (bus.s0_valid & bus.s1_valid) ? ~last_grant : bus.s1_valid;
                  busy_q  <= 1'b1;
                  state   <= SOF;
               end
            end
            SOF: begin
               if (send) begin
                  strobe_q <= 1'b1;
                  data_q   <= FLAG;
                  state    <= DATA;
               end
            end
            DATA: begin
               if (send && cur_valid) begin
                  strobe_q <= 1'b1;
                  if (cur_special) begin
                     // ack is deferred to the second half of the escape pair
                     data_q   <= ESC;
                     esc_byte <= cur_data;
                     esc_last <= cur_last;
                     state    <= ESC2;
                  end else begin
                     data_q <= cur_data;
                     ack0_q <= ~owner_q;
                     ack1_q <= owner_q;
                     state  <= cur_last ? EOF : DATA;
                  end
               end
            end
            ESC2: begin
               if (send) begin
                  strobe_q <= 1'b1;
                  data_q   <= esc_byte ^ XORV;
                  ack0_q   <= ~owner_q;
                  ack1_q   <= owner_q;
                  state    <= esc_last ? EOF : DATA;
               end
            end
            EOF: begin
               if (send) begin
                  strobe_q   <= 1'b1;
                  data_q     <= FLAG;
                  last_grant <= owner_q;
                  state      <= IDLE;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

   assign bus.tx_strobe = strobe_q;
   assign bus.tx_data   = data_q;
   assign bus.s0_ack    = ack0_q;
   assign bus.s1_ack    = ack1_q;
   assign bus.busy      = busy_q;
   assign bus.owner     = owner_q;

endmodule

// File: tb/tb_serial_tx_arbiter.sv
// tb_serial_tx_arbiter
//   Drives two packet sources and a UART ready model. Expected strobe stream
//   is built from whole packets: each frame is FLAG, escaped payload, FLAG,
//   with the source ack on the final encoding of every payload byte.
module tb_serial_tx_arbiter;
   localparam logic [7:0] FLAG = 8'h7E;
   localparam logic [7:0] ESC  = 8'h7D;
   localparam logic [7:0] XORV = 8'h20;

   logic mclk = 1'b0;
   logic reset = 1'b0;
   always #5 mclk = ~mclk;

   serial_tx_arbiter_if bus();

   serial_tx_arbiter #(.FLAG(FLAG), .ESC(ESC), .XORV(XORV)) dut (
      .mclk  (mclk),
      .reset (reset),
      .bus   (bus)
   );

   int total = 0;
   int bad   = 0;

   logic [8:0] sq0[$];   // {last, data} still to be offered by source 0
   logic [8:0] sq1[$];
   int         expq[$];  // {owner, ack1, ack0, busy, data} per expected strobe
   logic [7:0] pk[$];    // scratch packet payload

   int  nstb = 0, nack1 = 0, viol = 0;
   bit  prev_stb = 0;
   bit  rdy_rand = 0;
   int  rcnt = 0;
   bit  arm0 = 0;
   int  stall0 = 0;
   bit  last_owner = 1;

   task automatic chk(input string tag, input int got, input int exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   function automatic int mk(input bit src, input bit ack, input logic [7:0] d);
      int r;
      r = {24'd0, d};
      r[8]  = 1'b1;
      r[11] = src;
      if (ack) r[src ? 10 : 9] = 1'b1;
      return r;
   endfunction

   // Queue pk on a source and append its frame to the expected stream.
   task automatic add_pkt(input bit src);
      logic [8:0] e;
      for (int i = 0; i < pk.size(); i++) begin
         e = {(i == pk.size() - 1), pk[i]};
         if (src) sq1.push_back(e); else sq0.push_back(e);
      end
      expq.push_back(mk(src, 0, FLAG));
      for (int i = 0; i < pk.size(); i++) begin
         if (pk[i] == FLAG || pk[i] == ESC) begin
            expq.push_back(mk(src, 0, ESC));
            expq.push_back(mk(src, 1, pk[i] ^ XORV));
         end else begin
            expq.push_back(mk(src, 1, pk[i]));
         end
      end
      expq.push_back(mk(src, 0, FLAG));
   endtask

   task automatic gen_pk();
      int n;
      pk.delete();
      n = $urandom_range(1, 5);
      for (int i = 0; i < n; i++) begin
         case ($urandom % 4)
            0: pk.push_back(FLAG);
            1: pk.push_back(ESC);
            default: pk.push_back(8'($urandom));
         endcase
      end
   endtask

   task automatic tick();
      @(posedge mclk);
      #1;
   endtask

   task automatic drain(input string tag);
      int c = 0;
      while ((expq.size() != 0 || sq0.size() != 0 || sq1.size() != 0 || bus.busy) && c < 20000) begin
         tick();
         c++;
      end
      chk({tag, "_left"}, expq.size(), 0);
      chk({tag, "_busy"}, 32'(bus.busy), 0);
   endtask

   task automatic pulse_reset();
      reset = 1'b0;
      sq0.delete();
      sq1.delete();
      expq.delete();
      repeat (3) tick();
      reset = 1'b1;
      last_owner = 1;
      repeat (2) tick();
   endtask

   // source 0 driver (with optional stall after the next ack)
   initial begin
      bus.s0_valid = 0; bus.s0_data = 0; bus.s0_last = 0;
      forever begin
         @(negedge mclk);
         if (bus.s0_ack && sq0.size() > 0) begin
            void'(sq0.pop_front());
            if (arm0) begin stall0 = 1000; arm0 = 0; end
         end else if (stall0 > 0) stall0--;
         if (sq0.size() > 0 && stall0 == 0) begin
            bus.s0_valid = 1;
            {bus.s0_last, bus.s0_data} = sq0[0];
         end else bus.s0_valid = 0;
      end
   end

   // source 1 driver
   initial begin
      bus.s1_valid = 0; bus.s1_data = 0; bus.s1_last = 0;
      forever begin
         @(negedge mclk);
         if (bus.s1_ack && sq1.size() > 0) void'(sq1.pop_front());
         if (sq1.size() > 0) begin
            bus.s1_valid = 1;
            {bus.s1_last, bus.s1_data} = sq1[0];
         end else bus.s1_valid = 0;
      end
   end

   // UART ready model: tied high, or low for a random while after each strobe
   initial begin
      bus.tx_ready = 1;
      forever begin
         @(negedge mclk);
         if (!rdy_rand) bus.tx_ready = 1;
         else if (bus.tx_strobe) begin bus.tx_ready = 0; rcnt = $urandom_range(1, 8); end
         else if (rcnt > 0) rcnt--;
         else bus.tx_ready = 1;
      end
   end

   // strobe monitor
   initial begin
      int e;
      forever begin
         @(negedge mclk);
         if (reset) begin
            if ((bus.s0_ack || bus.s1_ack) && !bus.tx_strobe) viol++;
            if (bus.s0_ack && bus.s1_ack) viol++;
            if (bus.tx_strobe && prev_stb) viol++;
            if (bus.s1_ack) nack1++;
            if (bus.tx_strobe) begin
               nstb++;
               e = (expq.size() > 0) ? expq.pop_front() : -1;
               chk("strobe", {bus.owner, bus.s1_ack, bus.s0_ack, bus.busy, bus.tx_data}, e);
            end
            prev_stb = bus.tx_strobe;
         end else prev_stb = 0;
      end
   end

   initial begin
      int k, c, snap, snap_a;
      bit b1, b2, s;

      // reset state
      repeat (3) tick();
      chk("reset_outs", {bus.tx_data, bus.tx_strobe, bus.s0_ack, bus.s1_ack, bus.busy, bus.owner}, 0);
      reset = 1'b1;
      repeat (2) tick();

      // single packet with grant latency, ready tied high
      pk = '{8'h01, 8'h02};
      add_pkt(0);
      k = 0; b1 = 1; b2 = 0;
      while (k < 20) begin
         @(negedge mclk);
         k++;
         if (k == 1) b1 = bus.busy;
         if (k == 2) b2 = bus.busy;
         if (bus.tx_strobe) break;
      end
      chk("sof_latency", k, 3);
      chk("busy_before_grant", 32'(b1), 0);
      chk("busy_after_grant", 32'(b2), 1);
      tick();
      drain("single");

      // escaping
      rdy_rand = 1;
      pk = '{8'h7E, 8'h7D, 8'h20};
      add_pkt(1);
      drain("escape");

      // tie after reset, then immediate re-request: owners 0,1,0
      pulse_reset();
      pk = '{8'hAA}; add_pkt(0);
      pk = '{8'hBB}; add_pkt(1);
      pk = '{8'hCC}; add_pkt(0);
      drain("tie");

      // owner stall while the other source requests
      arm0 = 1;
      pk = '{8'h11, 8'h22}; add_pkt(0);
      c = 0;
      do begin @(negedge mclk); c++; end while (!bus.s0_ack && c < 200);
      chk("stall_first_ack", 32'(bus.s0_ack), 1);
      tick();
      pk = '{8'h44}; add_pkt(1);
      snap = nstb; snap_a = nack1;
      repeat (500) tick();
      chk("stall_strobes", nstb - snap, 0);
      chk("stall_ack1", nack1 - snap_a, 0);
      chk("stall_busy", 32'(bus.busy), 1);
      chk("stall_owner", 32'(bus.owner), 0);
      drain("stall");

      // reset in the middle of a packet
      pk = '{8'h01, 8'h02, 8'h03, 8'h04, 8'h05}; add_pkt(0);
      c = 0;
      do begin @(negedge mclk); c++; end while (!bus.s0_ack && c < 200);
      chk("mid_first_ack", 32'(bus.s0_ack), 1);
      @(posedge mclk);
      #2 reset = 1'b0;
      #1 chk("mid_reset_outs",
             {bus.tx_data, bus.tx_strobe, bus.s0_ack, bus.s1_ack, bus.busy, bus.owner}, 0);
      sq0.delete(); sq1.delete(); expq.delete();
      repeat (3) tick();
      reset = 1'b1;
      repeat (2) tick();
      pk = '{8'h33}; add_pkt(1);
      drain("after_reset");

      // strobe guard with ready tied high: 2 + 4 payload + 2 escapes = 8 strobes
      rdy_rand = 0;
      snap = nstb;
      pk = '{8'h7E, 8'h05, 8'h7D, 8'h09}; add_pkt(0);
      drain("guard");
      chk("guard_count", nstb - snap, 8);
      last_owner = 0;

      // both sources backlogged: strict alternation
      rdy_rand = 1;
      for (int it = 0; it < 2; it++) begin
         s = ~last_owner;
         for (int j = 0; j < 5; j++) begin
            gen_pk(); add_pkt(s);
            gen_pk(); add_pkt(~s);
         end
         last_owner = ~s;
         drain("backlog");
      end

      // single random source
      for (int it = 0; it < 3; it++) begin
         s = 1'($urandom);
         for (int j = 0; j < 3; j++) begin gen_pk(); add_pkt(s); end
         last_owner = s;
         drain("solo");
      end

      chk("protocol", viol, 0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   initial begin
      #5000000;
      $display("FAIL watchdog got=timeout exp=finish");
      $fatal(1);
   end
endmodule
